// File: rtl/ship_projectile_bank_pkg.sv
// galaga_lib: shared projectile constants, coordinate type and slot state encoding.
package galaga_lib;
    localparam int NP         = 10;
    localparam int PROJ_SPEED = 4;
    localparam int Y_MIN      = 0;
    localparam int X_OFS      = 7;
    localparam int PROJ_H     = 8;
    typedef logic [9:0] coord_t;
    typedef enum logic {P_IDLE, P_FLY} proj_state_t;
    localparam coord_t Y_LIM     = coord_t'(Y_MIN + PROJ_SPEED);
    localparam coord_t SPAWN_LIM = coord_t'(Y_MIN + PROJ_H);
endpackage

// File: rtl/ship_projectile_slot.sv
// ship_projectile_slot: one projectile slot FSM with its coordinate and retire-pulse registers.
module ship_projectile_slot
    import galaga_lib::*;
(
    input  logic   frame_clk,
    input  logic   Reset,
    input  logic   i_spawn,
    input  logic   i_hit,
    input  coord_t i_ship_x,
    input  coord_t i_ship_y,
    output logic   o_en,
    output coord_t o_x,
    output coord_t o_y,
    output logic   o_retire
);
    proj_state_t r_state, w_state;
    coord_t      r_x, r_y, w_x, w_y;
    logic        r_ret, w_ret;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= P_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_ret   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_ret   <= w_ret;
        end
    end

    // Hit beats the off-screen test and the move; compare before subtract avoids wrap.
    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_y     = r_y;
        w_ret   = 1'b0;
        if (r_state == P_FLY) begin
            if (i_hit || r_y < Y_LIM) begin
                w_state = P_IDLE;
                w_ret   = 1'b1;
            end else begin
                w_y = r_y - coord_t'(PROJ_SPEED);
            end
        end else if (i_spawn) begin
            w_state = P_FLY;
            w_x     = i_ship_x + coord_t'(X_OFS);
            w_y     = (i_ship_y < SPAWN_LIM) ? coord_t'(Y_MIN) : i_ship_y - coord_t'(PROJ_H);
        end
    end

    assign o_en     = (r_state == P_FLY);
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_retire = r_ret;
endmodule

// File: rtl/ship_projectile_bank.sv
// ship_projectile_bank: NP player-projectile slots spawned on rising ProjActvt edges.
// Optional SHIP_PROJ_HIT_CNT_EN adds a saturating HitCount of frames with hit retires.
module ship_projectile_bank
    import galaga_lib::*;
(
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic [NP-1:0]    ProjActvt,
    input  coord_t           ShipX,
    input  coord_t           ShipY,
    input  logic [NP-1:0]    HitMask,
    output logic [NP-1:0]    ProjEn,
    output logic [NP*10-1:0] ProjX,
    output logic [NP*10-1:0] ProjY,
    output logic [NP-1:0]    ProjRetire
`ifdef SHIP_PROJ_HIT_CNT_EN
    ,
    output logic [15:0]      HitCount
`endif
);
    logic [NP-1:0] r_act_q, w_rise, w_sel;
    logic          r_armed;

    // r_armed masks the first edge after reset so a request held through reset does not spawn.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_act_q <= '0;
            r_armed <= 1'b0;
        end else begin
            r_act_q <= ProjActvt;
            r_armed <= 1'b1;
        end
    end

    assign w_rise = r_armed ? (ProjActvt & ~r_act_q) : '0;
    assign w_sel  = w_rise & (~w_rise + NP'(1));

    for (genvar g = 0; g < NP; g++) begin : g_slot
        ship_projectile_slot u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .i_spawn   (w_sel[g]),
            .i_hit     (HitMask[g]),
            .i_ship_x  (ShipX),
            .i_ship_y  (ShipY),
            .o_en      (ProjEn[g]),
            .o_x       (ProjX[10*g +: 10]),
            .o_y       (ProjY[10*g +: 10]),
            .o_retire  (ProjRetire[g])
        );
    end

`ifdef SHIP_PROJ_HIT_CNT_EN
    logic [15:0] r_hit_cnt;
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            r_hit_cnt <= '0;
        else if (|(HitMask & ProjEn) && r_hit_cnt != 16'hFFFF)
            r_hit_cnt <= r_hit_cnt + 16'd1;
    end
    assign HitCount = r_hit_cnt;
`endif
endmodule

// File: tb/tb_ship_projectile_bank.sv
// tb_ship_projectile_bank: table vectors, corner sequences and random frames against a slot-array model.
module tb_ship_projectile_bank;
    import galaga_lib::*;
    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    act, hit;
    logic [9:0]       sx, sy;
    logic [NP-1:0]    en, ret;
    logic [NP*10-1:0] px, py;
`ifdef SHIP_PROJ_HIT_CNT_EN
    logic [15:0]      hc;
    int               m_hc;
`endif
    int tests = 0, fails = 0;
    int m_en[NP], m_x[NP], m_y[NP], m_ret[NP];
    logic [NP-1:0] m_act;
    bit m_armed;

    typedef struct {
        logic [NP-1:0] act;
        int            sx, sy;
        logic [NP-1:0] hit, en, ret;
        int            y0, y2;
    } vec_t;
    vec_t tbl[9];

    ship_projectile_bank dut (
        .frame_clk (clk),
        .Reset     (rst),
        .ProjActvt (act),
        .ShipX     (sx),
        .ShipY     (sy),
        .HitMask   (hit),
        .ProjEn    (en),
        .ProjX     (px),
        .ProjY     (py),
        .ProjRetire(ret)
`ifdef SHIP_PROJ_HIT_CNT_EN
        ,
        .HitCount  (hc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NP*10-1:0] got, input logic [NP*10-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin
            m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_ret[i] = 0;
        end
        m_act = '0;
        m_armed = 0;
`ifdef SHIP_PROJ_HIT_CNT_EN
        m_hc = 0;
`endif
    endfunction

    function automatic void model_step(input logic [NP-1:0] a, input int x, input int y, input logic [NP-1:0] h);
        int k;
        bit any_hit;
        k = -1;
        any_hit = 0;
        for (int i = 0; i < NP; i++)
            if (m_armed && a[i] && !m_act[i] && k < 0) k = i;
        for (int i = 0; i < NP; i++) begin
            m_ret[i] = 0;
            if (m_en[i] != 0) begin
                if (h[i] || m_y[i] < 4) begin
                    m_en[i] = 0;
                    m_ret[i] = 1;
                    if (h[i]) any_hit = 1;
                end else m_y[i] -= 4;
            end else if (i == k) begin
                m_en[i] = 1;
                m_x[i] = (x + 7) % 1024;
                m_y[i] = (y < 8) ? 0 : y - 8;
            end
        end
        m_act = a;
        m_armed = 1;
`ifdef SHIP_PROJ_HIT_CNT_EN
        if (any_hit && m_hc < 65535) m_hc++;
`endif
    endfunction

    task automatic compare_model();
        logic [NP*10-1:0] ex, ey;
        logic [NP-1:0] ee, er;
        for (int i = 0; i < NP; i++) begin
            ee[i] = (m_en[i] != 0);
            er[i] = (m_ret[i] != 0);
            ex[10*i +: 10] = 10'(m_x[i]);
            ey[10*i +: 10] = 10'(m_y[i]);
        end
        check("model_en", 100'(en), 100'(ee));
        check("model_ret", 100'(ret), 100'(er));
        check("model_x", px, ex);
        check("model_y", py, ey);
`ifdef SHIP_PROJ_HIT_CNT_EN
        check("model_hitcount", 100'(hc), 100'(m_hc));
`endif
    endtask

    task automatic frame(input logic [NP-1:0] a, input int x, input int y, input logic [NP-1:0] h);
        act = a; sx = 10'(x); sy = 10'(y); hit = h;
        model_step(a, x, y, h);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        int pulses, respawn;
        logic [NP-1:0] ra;
        tbl[0] = '{10'h000, 100, 400, 10'h000, 10'h000, 10'h000, 0, 0};
        tbl[1] = '{10'h001, 100, 400, 10'h000, 10'h001, 10'h000, 392, 0};
        tbl[2] = '{10'h001, 100, 400, 10'h000, 10'h001, 10'h000, 388, 0};
        tbl[3] = '{10'h000, 100, 400, 10'h000, 10'h001, 10'h000, 384, 0};
        tbl[4] = '{10'h004, 200, 208, 10'h000, 10'h005, 10'h000, 380, 200};
        tbl[5] = '{10'h004, 200, 208, 10'h004, 10'h001, 10'h004, 376, 200};
        tbl[6] = '{10'h000, 200, 208, 10'h000, 10'h001, 10'h000, 372, 200};
        tbl[7] = '{10'h000, 200, 208, 10'h004, 10'h001, 10'h000, 368, 200};
        tbl[8] = '{10'h006, 50, 300, 10'h000, 10'h003, 10'h000, 364, 200};

        rst = 1'b1; act = 10'h001; sx = '0; sy = '0; hit = '0;
        model_reset();
        #3;
        check("reset_en", 100'(en), 100'(0));
        check("reset_ret", 100'(ret), 100'(0));
        check("reset_x", px, '0);
        check("reset_y", py, '0);
        #10 rst = 1'b0;
        frame(10'h001, 100, 400, 10'h000);
        check("held_through_reset_no_spawn", 100'(en), 100'(0));

        for (int i = 0; i < 9; i++) begin
            frame(tbl[i].act, tbl[i].sx, tbl[i].sy, tbl[i].hit);
            check($sformatf("tbl%0d_en", i), 100'(en), 100'(tbl[i].en));
            check($sformatf("tbl%0d_ret", i), 100'(ret), 100'(tbl[i].ret));
            if (tbl[i].en[0]) check($sformatf("tbl%0d_y0", i), 100'(py[9:0]), 100'(tbl[i].y0));
            if (i >= 4) check($sformatf("tbl%0d_y2", i), 100'(py[29:20]), 100'(tbl[i].y2));
        end
        check("spawn_x1", 100'(px[19:10]), 100'(57));

        pulses = 0; respawn = 0;
        for (int f = 0; f < 120; f++) begin
            logic was;
            was = en[1];
            frame(10'h006, 50, 300, 10'h000);
            if (ret[1]) pulses++;
            if (!was && en[1]) respawn++;
        end
        check("held_slot1_retire_once", 100'(pulses), 100'(1));
        check("held_no_respawn", 100'(respawn), 100'(0));
        check("held_all_idle", 100'(en), 100'(0));

        frame(10'h000, 0, 11, 10'h000);
        frame(10'h001, 0, 11, 10'h000);
        check("y3_spawn", 100'(py[9:0]), 100'(3));
        frame(10'h000, 0, 11, 10'h000);
        check("y3_retire_en", 100'(en), 100'(0));
        check("y3_retire_pulse", 100'(ret), 100'(1));
        frame(10'h000, 0, 11, 10'h000);
        check("y3_pulse_one_frame", 100'(ret), 100'(0));

        frame(10'h001, 1020, 5, 10'h000);
        check("wrap_x", 100'(px[9:0]), 100'(3));
        check("sat_y", 100'(py[9:0]), 100'(0));
        frame(10'h000, 0, 0, 10'h000);
        check("sat_retire", 100'(ret), 100'(1));

        frame(10'h001, 10, 400, 10'h000);
        frame(10'h000, 10, 400, 10'h000);
        frame(10'h002, 10, 400, 10'h000);
        frame(10'h000, 10, 400, 10'h000);
        frame(10'h004, 10, 400, 10'h000);
        check("three_flying", 100'(en), 100'(10'h007));
        #2 rst = 1'b1;
        #1;
        check("async_reset_en", 100'(en), 100'(0));
        check("async_reset_ret", 100'(ret), 100'(0));
        @(posedge clk); #1;
        check("reset_held_no_pulse", 100'(ret), 100'(0));
        model_reset();
        #2 rst = 1'b0;

        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 3) == 0) ra = NP'($urandom);
            else if ($urandom_range(0, 1) == 0) ra = NP'(1) << $urandom_range(0, NP - 1);
            else ra = '0;
            frame(ra, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  ($urandom_range(0, 4) == 0) ? NP'($urandom) : '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
